// File: rtl/serial_magnitude_comparator_if.sv
// serial_magnitude_comparator_if: start/result handshake and operand bus for the serial comparator
interface serial_magnitude_comparator_if #(parameter int WIDTH = 8);
  logic start, ready, result_valid, result_ack, gt, eq, lt;
  logic [WIDTH-1:0] a, b;
  modport master (output start, a, b, result_ack, input ready, result_valid, gt, eq, lt);
  modport slave (input start, a, b, result_ack, output ready, result_valid, gt, eq, lt);
endinterface

// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator: bit-serial unsigned compare, one bit per clock, LSB- or MSB-first
module serial_magnitude_comparator #(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input logic clk,
  input logic rst_n,
  serial_magnitude_comparator_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] sa, sb;
  logic [CW-1:0] cnt;
  logic gt_acc, lt_acc, gt_nx, lt_nx, ai, bi, last, gt_q, eq_q, lt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == IDLE && bus.start) state_nx = SHIFT;
    else if (state == SHIFT && last) state_nx = DONE;
    else if (state == DONE && bus.result_ack) state_nx = IDLE;
  end
  // LSB-first lets each higher differing bit overwrite; MSB-first freezes on the first difference
  always_comb begin
    ai = MSB_FIRST ? sa[WIDTH-1] : sa[0];
    bi = MSB_FIRST ? sb[WIDTH-1] : sb[0];
    last = cnt == CW'(WIDTH - 1);
    gt_nx = MSB_FIRST ? (gt_acc | (~lt_acc & ai & ~bi)) : ((ai & ~bi) | (~(ai ^ bi) & gt_acc));
    lt_nx = MSB_FIRST ? (lt_acc | (~gt_acc & ~ai & bi)) : ((~ai & bi) | (~(ai ^ bi) & lt_acc));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sa <= '0;
      sb <= '0;
      cnt <= '0;
      gt_acc <= 1'b0;
      lt_acc <= 1'b0;
      gt_q <= 1'b0;
      eq_q <= 1'b0;
      lt_q <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      sa <= bus.a;
      sb <= bus.b;
      cnt <= '0;
      gt_acc <= 1'b0;
      lt_acc <= 1'b0;
      gt_q <= 1'b0;
      eq_q <= 1'b0;
      lt_q <= 1'b0;
    end else if (state == SHIFT) begin
      sa <= MSB_FIRST ? sa << 1 : sa >> 1;
      sb <= MSB_FIRST ? sb << 1 : sb >> 1;
      cnt <= cnt + CW'(1);
      gt_acc <= gt_nx;
      lt_acc <= lt_nx;
      if (last) begin
        gt_q <= gt_nx;
        lt_q <= lt_nx;
        eq_q <= ~(gt_nx | lt_nx);
      end
    end
  assign bus.ready = state == IDLE;
  assign bus.result_valid = state == DONE;
  assign bus.gt = gt_q;
  assign bus.eq = eq_q;
  assign bus.lt = lt_q;
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// tb_serial_magnitude_comparator: directed and random checks of both scan orders and WIDTH=1
module tb_serial_magnitude_comparator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vecs = 0;
  int errs = 0;
  always #5 clk = ~clk;
  serial_magnitude_comparator_if #(.WIDTH(8)) if8l ();
  serial_magnitude_comparator_if #(.WIDTH(8)) if8m ();
  serial_magnitude_comparator_if #(.WIDTH(1)) if1 ();
  serial_magnitude_comparator #(.WIDTH(8), .MSB_FIRST(1'b0)) u8l (.clk(clk), .rst_n(rst_n), .bus(if8l));
  serial_magnitude_comparator #(.WIDTH(8), .MSB_FIRST(1'b1)) u8m (.clk(clk), .rst_n(rst_n), .bus(if8m));
  serial_magnitude_comparator #(.WIDTH(1), .MSB_FIRST(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle_all(input string tag);
    chk({tag, "_ready_l"}, if8l.ready, 1);
    chk({tag, "_ready_m"}, if8m.ready, 1);
    chk({tag, "_ready_1"}, if1.ready, 1);
    chk({tag, "_valid_l"}, if8l.result_valid, 0);
    chk({tag, "_valid_m"}, if8m.result_valid, 0);
    chk({tag, "_valid_1"}, if1.result_valid, 0);
    chk({tag, "_res_l"}, {if8l.gt, if8l.eq, if8l.lt}, 0);
    chk({tag, "_res_m"}, {if8m.gt, if8m.eq, if8m.lt}, 0);
    chk({tag, "_res_1"}, {if1.gt, if1.eq, if1.lt}, 0);
  endtask
  // Drives the same operands into both 8-bit scan orders; disturb fires a stray start with new operands mid-scan
  task automatic cmp8(input logic [7:0] a, input logic [7:0] b, input bit disturb);
    int n;
    logic [2:0] exp;
    exp = {a > b, a == b, a < b};
    if8l.a = a; if8l.b = b; if8l.start = 1'b1;
    if8m.a = a; if8m.b = b; if8m.start = 1'b1;
    @(posedge clk); #1;
    if8l.start = 1'b0; if8m.start = 1'b0;
    chk("ready_drop_l", if8l.ready, 0);
    chk("ready_drop_m", if8m.ready, 0);
    n = 0;
    while (!if8l.result_valid && n < 20) begin
      if (disturb) begin
        if8l.start = n == 2; if8m.start = n == 2;
        if8l.a = 8'hFF; if8l.b = 8'h00; if8m.a = 8'hFF; if8m.b = 8'h00;
      end
      @(posedge clk); #1;
      n++;
    end
    if8l.start = 1'b0; if8m.start = 1'b0;
    chk("latency", n, 8);
    chk("valid_m", if8m.result_valid, 1);
    chk($sformatf("res_l_%02h_%02h", a, b), {if8l.gt, if8l.eq, if8l.lt}, exp);
    chk($sformatf("res_m_%02h_%02h", a, b), {if8m.gt, if8m.eq, if8m.lt}, exp);
    @(posedge clk); #1;
    chk("hold_valid", if8l.result_valid, 1);
    chk("hold_res", {if8l.gt, if8l.eq, if8l.lt}, exp);
    if8l.result_ack = 1'b1; if8m.result_ack = 1'b1;
    @(posedge clk); #1;
    if8l.result_ack = 1'b0; if8m.result_ack = 1'b0;
    chk("ack_ready_l", if8l.ready, 1);
    chk("ack_ready_m", if8m.ready, 1);
    chk("ack_valid_l", if8l.result_valid, 0);
    chk("idle_keep_l", {if8l.gt, if8l.eq, if8l.lt}, exp);
  endtask
  task automatic cmp1(input logic a, input logic b);
    logic [2:0] exp;
    exp = {a & ~b, a == b, ~a & b};
    if1.a = a; if1.b = b; if1.start = 1'b1;
    @(posedge clk); #1;
    if1.start = 1'b0;
    chk("w1_ready_drop", if1.ready, 0);
    @(posedge clk); #1;
    chk("w1_valid", if1.result_valid, 1);
    chk($sformatf("w1_res_%b%b", a, b), {if1.gt, if1.eq, if1.lt}, exp);
    if1.result_ack = 1'b1;
    @(posedge clk); #1;
    if1.result_ack = 1'b0;
    chk("w1_ack_ready", if1.ready, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int t, last, pulses;
    logic [7:0] ra, rb;
    if8l.start = 0; if8l.a = 0; if8l.b = 0; if8l.result_ack = 0;
    if8m.start = 0; if8m.a = 0; if8m.b = 0; if8m.result_ack = 0;
    if1.start = 0; if1.a = 0; if1.b = 0; if1.result_ack = 0;
    #12;
    chk_idle_all("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_idle_all("post_reset");
    cmp8(8'hA5, 8'h5A, 1'b0);
    cmp8(8'h3C, 8'h3C, 1'b0);
    cmp8(8'h00, 8'hFF, 1'b0);
    cmp8(8'h80, 8'h7F, 1'b0);
    cmp8(8'h01, 8'h80, 1'b0);
    cmp8(8'h10, 8'h20, 1'b1);
    for (int i = 0; i < 4; i++) cmp1(i[1], i[0]);
    if8l.a = 8'h77; if8l.b = 8'h11; if8l.start = 1'b1;
    if8m.a = 8'h77; if8m.b = 8'h11; if8m.start = 1'b1;
    if1.a = 1'b1; if1.b = 1'b0; if1.start = 1'b1;
    @(posedge clk); #1;
    if8l.start = 1'b0; if8m.start = 1'b0; if1.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_idle_all("async_reset");
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_idle_all("after_async_reset");
    cmp8(8'h01, 8'h00, 1'b0);
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = $urandom_range(3) == 0 ? ra : 8'($urandom);
      cmp8(ra, rb, 1'b0);
    end
    if8l.a = 8'h05; if8l.b = 8'h03; if8l.start = 1'b1; if8l.result_ack = 1'b1;
    last = -1;
    pulses = 0;
    for (t = 1; t <= 45; t++) begin
      @(posedge clk); #1;
      if (if8l.result_valid) begin
        chk("b2b_gt", {if8l.gt, if8l.eq, if8l.lt}, 3'b100);
        if (last >= 0) chk("b2b_period", t - last, 10);
        last = t;
        pulses++;
      end
    end
    chk("b2b_pulses", pulses, 4);
    if8l.start = 1'b0;
    repeat (12) @(posedge clk);
    #1 if8l.result_ack = 1'b0;
    chk("b2b_end_ready", if8l.ready, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
